// File: rtl/pb_pkg.sv
// rtl/pb_pkg.sv - shared constants and types for the push-button conditioner
package pb_pkg;

    localparam int PB_NUM                = 21;
    localparam int PB_CODE_W             = $clog2(PB_NUM);
    localparam int PB_TICK_DIV_DEFAULT   = 10000;
    localparam int PB_STABLE_CNT_DEFAULT = 4;

    typedef logic [PB_NUM-1:0] pb_vec_t;

    // Width of a counter or index covering n values, never narrower than 1 bit
    function automatic int pb_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pb_debounce_bit.sv
// rtl/pb_debounce_bit.sv - synchronizer, stable counter, level and edge strobes for one button
module pb_debounce_bit
    import pb_pkg::*;
#(
    parameter int STABLE_CNT = PB_STABLE_CNT_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int CNT_W = $clog2(STABLE_CNT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);

    logic             meta;
    logic             sync;
    logic [CNT_W-1:0] cnt;

    // Two-flop synchronizer, then on each tick count consecutive disagreements and commit on the last one
    always_ff @(posedge clk) begin
        if (reset) begin
            meta  <= 1'b0;
            sync  <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            meta <= raw;
            sync <= meta;
            rise <= 1'b0;
            fall <= 1'b0;
            if (tick) begin
                if (sync == level) begin
                    cnt <= '0;
                end else if (cnt == CNT_LAST) begin
                    level <= sync;
                    cnt   <= '0;
                    rise  <= sync;
                    fall  <= ~sync;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/pb_conditioner.sv
// rtl/pb_conditioner.sv - debounced push-button levels, edge strobes and lowest-held key code
module pb_conditioner
    import pb_pkg::*;
#(
    parameter  int NUM_PB     = PB_NUM,
    parameter  int TICK_DIV   = PB_TICK_DIV_DEFAULT,
    parameter  int STABLE_CNT = PB_STABLE_CNT_DEFAULT,
    localparam int CODE_W     = pb_width(NUM_PB)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_PB-1:0] pb_raw,
    output logic [NUM_PB-1:0] pb_level,
    output logic [NUM_PB-1:0] pb_press,
    output logic [NUM_PB-1:0] pb_release,
    output logic              key_valid,
    output logic [CODE_W-1:0] key_code,
    output logic              key_strobe
);

    localparam int DIV_W = pb_width(TICK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;
    logic             tick;

    assign tick = (div_cnt == DIV_LAST);

    // Shared sample-rate prescaler: counts 0..TICK_DIV-1, tick on the last count
    always_ff @(posedge clk) begin
        if (reset || tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    for (genvar g = 0; g < NUM_PB; g++) begin : g_bit
        pb_debounce_bit #(
            .STABLE_CNT (STABLE_CNT)
        ) u_bit (
            .clk   (clk),
            .reset (reset),
            .tick  (tick),
            .raw   (pb_raw[g]),
            .level (pb_level[g]),
            .rise  (pb_press[g]),
            .fall  (pb_release[g])
        );
    end

    // Priority encoder over debounced levels; scanning downward lets the lowest held index win
    always_comb begin
        key_code = '0;
        for (int i = NUM_PB - 1; i >= 0; i--) begin
            if (pb_level[i]) begin
                key_code = CODE_W'(i);
            end
        end
    end

    assign key_valid  = |pb_level;
    assign key_strobe = |pb_press;

endmodule

// File: tb/tb_pb_conditioner.sv
// tb/tb_pb_conditioner.sv - self-checking bench for pb_conditioner with a behavioural model
module tb_pb_conditioner;

    localparam int N  = 21;
    localparam int TD = 4;
    localparam int SC = 3;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] pb_raw = '0;
    logic [N-1:0] pb_level;
    logic [N-1:0] pb_press;
    logic [N-1:0] pb_release;
    logic         key_valid;
    logic [4:0]   key_code;
    logic         key_strobe;

    int n_assert = 0;
    int n_fail   = 0;

    // behavioural model state
    logic [N-1:0] m_d0, m_d1, m_level, m_press, m_rel;
    int           m_run [N];
    int           m_n;

    // scenario bookkeeping
    logic [N-1:0] raw;
    logic         rst;
    int           cnt_a, cnt_b, cnt_c, first;
    logic [4:0]   code_at;

    pb_conditioner #(
        .NUM_PB     (N),
        .TICK_DIV   (TD),
        .STABLE_CNT (SC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pb_raw     (pb_raw),
        .pb_level   (pb_level),
        .pb_press   (pb_press),
        .pb_release (pb_release),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .key_strobe (key_strobe)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] lowest(input logic [N-1:0] v);
        int k;
        if (v == '0) return 5'd0;
        k = 0;
        while (!v[k]) k++;
        return 5'(k);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Model of one clock edge: raw reaches the decision 2 edges late, decisions happen every TD-th edge
    task automatic model_edge(input logic [N-1:0] r, input logic rs);
        logic [N-1:0] s;
        bit           tick_edge;
        if (rs) begin
            m_d0 = '0; m_d1 = '0; m_level = '0; m_press = '0; m_rel = '0; m_n = 0;
            for (int i = 0; i < N; i++) m_run[i] = 0;
        end else begin
            s = m_d1;
            tick_edge = ((m_n % TD) == TD - 1);
            m_press = '0;
            m_rel = '0;
            if (tick_edge) begin
                for (int i = 0; i < N; i++) begin
                    if (s[i] != m_level[i]) begin
                        m_run[i]++;
                        if (m_run[i] == SC) begin
                            m_level[i] = s[i];
                            m_press[i] = s[i];
                            m_rel[i]   = ~s[i];
                            m_run[i]   = 0;
                        end
                    end else begin
                        m_run[i] = 0;
                    end
                end
            end
            m_d1 = m_d0;
            m_d0 = r;
            m_n++;
        end
    endtask

    task automatic check_all();
        chk("pb_level",   32'(pb_level),   32'(m_level));
        chk("pb_press",   32'(pb_press),   32'(m_press));
        chk("pb_release", 32'(pb_release), 32'(m_rel));
        chk("key_valid",  32'(key_valid),  32'(|m_level));
        chk("key_code",   32'(key_code),   32'(lowest(m_level)));
        chk("key_strobe", 32'(key_strobe), 32'(|m_press));
        chk("tick",       32'(dut.tick),   32'((m_n % TD) == TD - 1));
        chk("press_release_excl", 32'(pb_press & pb_release), 32'd0);
    endtask

    task automatic step(input logic [N-1:0] r, input logic rs);
        @(negedge clk);
        pb_raw = r;
        reset  = rs;
        @(posedge clk);
        model_edge(r, rs);
        #1;
        check_all();
    endtask

    initial begin
        // reset held 3 cycles with all buttons pressed, then quiet while the debounce fills
        raw = '1;
        for (int k = 0; k < 3; k++) step(raw, 1'b1);
        for (int k = 0; k < 11; k++) begin
            step(raw, 1'b0);
            chk("quiet_after_reset",
                32'((|pb_level) | (|pb_press) | (|pb_release) | key_valid | key_strobe | (|key_code)), 32'd0);
        end

        // single press on button 5
        step('0, 1'b1);
        raw = '0; raw[5] = 1'b1;
        cnt_a = 0; cnt_b = 0; first = -1;
        for (int k = 1; k <= 30; k++) begin
            step(raw, 1'b0);
            if (pb_press[5]) begin
                cnt_a++;
                if (first < 0) first = k;
            end
            if (key_strobe) cnt_b++;
        end
        chk("pb5_press_count", 32'(cnt_a), 32'd1);
        chk("pb5_strobe_count", 32'(cnt_b), 32'd1);
        chk("pb5_press_edge", 32'(first), 32'd12);
        chk("pb5_key_valid", 32'(key_valid), 32'd1);
        chk("pb5_key_code", 32'(key_code), 32'd5);

        // button 0 glitch lasting only 2 ticks
        step('0, 1'b1);
        raw = '0; raw[0] = 1'b1;
        cnt_a = 0; cnt_b = 0; cnt_c = 0;
        for (int k = 0; k < 28; k++) begin
            if (k == 8) raw = '0;
            step(raw, 1'b0);
            if (pb_level[0]) cnt_a++;
            if (pb_press[0]) cnt_b++;
            if (key_strobe) cnt_c++;
        end
        chk("glitch_level0", 32'(cnt_a), 32'd0);
        chk("glitch_press0", 32'(cnt_b), 32'd0);
        chk("glitch_strobe", 32'(cnt_c), 32'd0);

        // buttons 3 and 16 together, then release 3
        step('0, 1'b1);
        raw = '0; raw[3] = 1'b1; raw[16] = 1'b1;
        cnt_a = 0; cnt_b = 0; code_at = '1;
        for (int k = 0; k < 16; k++) begin
            step(raw, 1'b0);
            if (pb_press[3] && pb_press[16]) begin
                cnt_a++;
                code_at = key_code;
            end
            if (key_strobe) cnt_b++;
        end
        chk("dual_press_count", 32'(cnt_a), 32'd1);
        chk("dual_strobe_count", 32'(cnt_b), 32'd1);
        chk("dual_key_code", 32'(code_at), 32'd3);
        raw[3] = 1'b0;
        cnt_a = 0; cnt_b = 0;
        for (int k = 0; k < 16; k++) begin
            step(raw, 1'b0);
            if (pb_release[3]) cnt_a++;
            if (key_strobe) cnt_b++;
        end
        chk("rel3_count", 32'(cnt_a), 32'd1);
        chk("rel3_no_strobe", 32'(cnt_b), 32'd0);
        chk("rel3_key_code", 32'(key_code), 32'd16);
        chk("rel3_key_valid", 32'(key_valid), 32'd1);

        // button 7 held, reset pulsed mid-debounce
        step('0, 1'b1);
        raw = '0; raw[7] = 1'b1;
        cnt_a = 0;
        for (int k = 0; k < 8; k++) begin
            step(raw, 1'b0);
            if (pb_press[7]) cnt_a++;
        end
        chk("pb7_no_early_press", 32'(cnt_a), 32'd0);
        step(raw, 1'b1);
        chk("pb7_reset_clear", 32'((|pb_level) | (|pb_press) | key_valid | key_strobe), 32'd0);
        first = -1;
        for (int k = 1; k <= 20; k++) begin
            step(raw, 1'b0);
            if (pb_press[7] && first < 0) first = k;
        end
        chk("pb7_refire_edge", 32'(first), 32'd12);

        // randomized button activity with occasional resets
        step('0, 1'b1);
        raw = '0;
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 3) == 0) raw[$urandom_range(0, N - 1)] ^= 1'b1;
            if ($urandom_range(0, 15) == 0) raw[$urandom_range(0, N - 1)] ^= 1'b1;
            rst = ($urandom_range(0, 299) == 0);
            step(raw, rst);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
